// File: rtl/mc14500_sequencer.sv
// rtl/mc14500_sequencer.sv - MC14500 ICU program sequencer; SEQ_STACK_EN adds the return stack
module mc14500_sequencer #(
   parameter int ADDR_W      = 8,
   parameter int STACK_DEPTH = 4
) (
   input  logic              X2,
   input  logic              RST_N,
   output logic [ADDR_W-1:0] ROM_ADDR,
   input  logic [ADDR_W+3:0] ROM_DATA,
   output logic [3:0]        I,
   output logic [3:0]        IO_ADDR,
   input  logic              JMP,
   input  logic              RTN,
   input  logic              FLAG_F,
   input  logic              RESUME,
   output logic              HALTED,
   output logic              STK_ERR
);

   if (STACK_DEPTH < 2 || (STACK_DEPTH & (STACK_DEPTH - 1)) != 0) begin : g_depth_check
      $error("STACK_DEPTH must be a power of two, at least 2");
   end

   logic [ADDR_W-1:0] pc;
   logic [ADDR_W+3:0] ir;
   logic              halted;
   logic [ADDR_W-1:0] pc_inc;

   assign pc_inc = pc + ADDR_W'(1);

`ifdef SEQ_STACK_EN
   localparam int SP_W  = $clog2(STACK_DEPTH);
   localparam int CNT_W = SP_W + 1;

   logic [ADDR_W-1:0] stk [STACK_DEPTH];
   logic [SP_W-1:0]   sp;
   logic [CNT_W-1:0]  cnt;
   logic              stk_err;
   logic [SP_W-1:0]   sp_dec;

   assign sp_dec  = sp - SP_W'(1);
   assign STK_ERR = stk_err;
`else
   assign STK_ERR = 1'b0;
`endif

   always_ff @(posedge X2) begin
      if (!RST_N) begin
         pc     <= '0;
         ir     <= '0;
         halted <= 1'b0;
`ifdef SEQ_STACK_EN
         sp      <= '0;
         cnt     <= '0;
         stk_err <= 1'b0;
`endif
      end else if (halted) begin
         if (RESUME) begin
            halted <= 1'b0;
         end
      end else if (JMP) begin
         // IR still holds the JMP word, so its operand is the target
         pc <= ir[ADDR_W-1:0];
         ir <= ROM_DATA;
`ifdef SEQ_STACK_EN
         // A full stack wraps onto its oldest entry
         stk[sp] <= pc_inc;
         sp      <= sp + SP_W'(1);
         if (cnt == CNT_W'(STACK_DEPTH)) begin
            stk_err <= 1'b1;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
`endif
      end else if (RTN) begin
         ir <= ROM_DATA;
`ifdef SEQ_STACK_EN
         if (cnt != '0) begin
            pc  <= stk[sp_dec];
            sp  <= sp_dec;
            cnt <= cnt - CNT_W'(1);
         end else begin
            pc      <= '0;
            stk_err <= 1'b1;
         end
`else
         pc <= pc_inc;
`endif
      end else if (FLAG_F) begin
         halted <= 1'b1;
      end else begin
         ir <= ROM_DATA;
         pc <= pc_inc;
      end
   end

   assign ROM_ADDR = pc;
   assign I        = halted ? 4'hF : ir[ADDR_W+3:ADDR_W];
   assign IO_ADDR  = ir[3:0];
   assign HALTED   = halted;

endmodule

// File: tb/tb_mc14500_sequencer.sv
// tb/tb_mc14500_sequencer.sv - self-checking bench for mc14500_sequencer with an ICU model
module tb_mc14500_sequencer;

   localparam int AW    = 8;
   localparam int DEPTH = 4;
   localparam logic [3:0] OP_JMP  = 4'hC;
   localparam logic [3:0] OP_RTN  = 4'hD;
   localparam logic [3:0] OP_NOPF = 4'hF;

   logic          x2     = 1'b0;
   logic          rst_n  = 1'b0;
   logic          resume = 1'b0;
   logic [AW+3:0] rom [256];
   logic [AW-1:0] rom_addr;
   logic [AW+3:0] rom_data;
   logic [3:0]    i_op;
   logic [3:0]    io_addr;
   logic          jmp;
   logic          rtn;
   logic          flag_f = 1'b0;
   logic          halted;
   logic          stk_err;

   logic [7:0]    rom4 [16];
   logic [3:0]    rom4_addr;
   logic [7:0]    rom4_data;
   logic [3:0]    i4;
   logic [3:0]    io4;
   logic          halted4;
   logic          stk_err4;

   int n_chk  = 0;
   int n_fail = 0;

   mc14500_sequencer #(.ADDR_W(AW), .STACK_DEPTH(DEPTH)) u_dut (
      .X2(x2), .RST_N(rst_n), .ROM_ADDR(rom_addr), .ROM_DATA(rom_data),
      .I(i_op), .IO_ADDR(io_addr), .JMP(jmp), .RTN(rtn), .FLAG_F(flag_f),
      .RESUME(resume), .HALTED(halted), .STK_ERR(stk_err)
   );

   mc14500_sequencer #(.ADDR_W(4), .STACK_DEPTH(DEPTH)) u_dut4 (
      .X2(x2), .RST_N(rst_n), .ROM_ADDR(rom4_addr), .ROM_DATA(rom4_data),
      .I(i4), .IO_ADDR(io4), .JMP(1'b0), .RTN(1'b0), .FLAG_F(1'b0),
      .RESUME(1'b0), .HALTED(halted4), .STK_ERR(stk_err4)
   );

   assign rom_data  = rom[rom_addr];
   assign rom4_data = rom4[rom4_addr];

   always #5 x2 = ~x2;

   // ICU model: latches I on the falling edge, JMP/RTN follow the latched
   // opcode, FLAG_F pulses for the cycle after NOPF executes
   logic [3:0] lat_op = 4'h0;
   logic       lat_ok = 1'b0;
   always @(negedge x2) begin
      lat_op = rst_n ? i_op : 4'h0;
      lat_ok = rst_n && !halted;
   end
   assign jmp = lat_ok && (lat_op == OP_JMP);
   assign rtn = lat_ok && (lat_op == OP_RTN);
   always @(posedge x2) flag_f <= rst_n && lat_ok && (lat_op == OP_NOPF);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge x2);
      #2;
   endtask

   function automatic logic [3:0] fop(input int a);
      return 4'((a + 1) % 11);
   endfunction

   task automatic fill();
      for (int a = 0; a < 256; a++) rom[a] = {fop(a), 8'(a)};
      for (int a = 0; a < 16; a++) rom4[a] = {fop(a), 4'(a)};
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      repeat (n) tick();
      rst_n = 1'b1;
   endtask

   // Architectural reference: address in IR (-1 = reset NOPO), fetch address, LIFO
   int   m_ir;
   int   m_pc;
   int   m_stk[$];
   logic m_err;

   task automatic model_reset();
      m_ir = -1;
      m_pc = 0;
      m_stk.delete();
      m_err = 1'b0;
   endtask

   task automatic model_edge();
      logic [3:0] op;
      int nxt;
      op  = (m_ir < 0) ? 4'h0 : rom[m_ir][11:8];
      nxt = (m_pc + 1) % 256;
      if (op == OP_JMP) begin
         nxt = int'(rom[m_ir][7:0]);
`ifdef SEQ_STACK_EN
         m_stk.push_back((m_pc + 1) % 256);
         if (m_stk.size() > DEPTH) begin
            void'(m_stk.pop_front());
            m_err = 1'b1;
         end
`endif
      end else if (op == OP_RTN) begin
`ifdef SEQ_STACK_EN
         if (m_stk.size() == 0) begin
            nxt   = 0;
            m_err = 1'b1;
         end else begin
            nxt = m_stk.pop_back();
         end
`endif
      end
      m_ir = m_pc;
      m_pc = nxt;
   endtask

   task automatic model_check(input int cyc);
      chk($sformatf("rnd_addr@%0d", cyc), 32'(rom_addr), 32'(m_pc));
      chk($sformatf("rnd_op@%0d", cyc), 32'(i_op), (m_ir < 0) ? 32'h0 : 32'(rom[m_ir][11:8]));
      chk($sformatf("rnd_io@%0d", cyc), 32'(io_addr), (m_ir < 0) ? 32'h0 : 32'(rom[m_ir][3:0]));
      chk($sformatf("rnd_err@%0d", cyc), 32'(stk_err), 32'(m_err));
      chk($sformatf("rnd_halt@%0d", cyc), 32'(halted), 32'h0);
   endtask

   initial begin
      logic [7:0] exp_ret;
      logic       exp_err;
      int         r;
      logic [3:0] op;

      // Reset and linear fetch, with the 4-bit instance checking wrap
      fill();
      rst_n = 1'b0;
      for (int n = 0; n < 3; n++) begin
         tick();
         chk("rst_addr", 32'(rom_addr), 32'h0);
         chk("rst_op", 32'(i_op), 32'h0);
         chk("rst_io", 32'(io_addr), 32'h0);
         chk("rst_halt", 32'(halted), 32'h0);
         chk("rst_err", 32'(stk_err), 32'h0);
      end
      rst_n = 1'b1;
      for (int n = 1; n <= 17; n++) begin
         tick();
         chk($sformatf("wrap_addr%0d", n), 32'(rom4_addr), 32'(n % 16));
         chk($sformatf("wrap_op%0d", n), 32'(i4), 32'(fop((n - 1) % 16)));
         if (n <= 2) begin
            chk($sformatf("lin_addr%0d", n), 32'(rom_addr), 32'(n));
            chk($sformatf("lin_op%0d", n), 32'(i_op), 32'(fop(n - 1)));
         end
      end

      // JMP with delay slot
      fill();
      rom[8'h10] = {OP_JMP, 8'h40};
      do_reset(1);
      repeat (17) tick();
      chk("jmp_in_ir_op", 32'(i_op), 32'(OP_JMP));
      chk("jmp_in_ir_addr", 32'(rom_addr), 32'h11);
      tick();
      chk("jmp_slot_op", 32'(i_op), 32'(fop(8'h11)));
      chk("jmp_slot_addr", 32'(rom_addr), 32'h40);
      tick();
      chk("jmp_tgt_op", 32'(i_op), 32'(fop(8'h40)));
      chk("jmp_tgt_io", 32'(io_addr), 32'h0);
      chk("jmp_tgt_addr", 32'(rom_addr), 32'h41);
      tick();
      chk("jmp_tgt1_op", 32'(i_op), 32'(fop(8'h41)));
      chk("jmp_tgt1_addr", 32'(rom_addr), 32'h42);

      // Call and return
      fill();
      rom[8'h10] = {OP_JMP, 8'h40};
      rom[8'h40] = {OP_RTN, 8'h40};
`ifdef SEQ_STACK_EN
      exp_ret = 8'h12;
`else
      exp_ret = 8'h42;
`endif
      do_reset(1);
      repeat (19) tick();
      chk("ret_rtn_op", 32'(i_op), 32'(OP_RTN));
      chk("ret_rtn_addr", 32'(rom_addr), 32'h41);
      tick();
      chk("ret_slot_op", 32'(i_op), 32'(fop(8'h41)));
      chk("ret_slot_addr", 32'(rom_addr), 32'(exp_ret));
      tick();
      chk("ret_back_op", 32'(i_op), 32'(fop(int'(exp_ret))));
      chk("ret_err", 32'(stk_err), 32'h0);

      // Five nested JMPs overflow a four-entry stack
      fill();
      for (int k = 1; k <= 5; k++) rom[8'(k * 16)] = {OP_JMP, 8'((k + 1) * 16)};
`ifdef SEQ_STACK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      do_reset(1);
      repeat (25) tick();
      chk("nest4_err", 32'(stk_err), 32'h0);
      tick();
      chk("nest5_err", 32'(stk_err), 32'(exp_err));
      chk("nest5_addr", 32'(rom_addr), 32'h60);

      // Halt on NOPF at 0x20 and resume
      fill();
      rom[8'h10] = {OP_JMP, 8'h20};
      rom[8'h20] = {OP_NOPF, 8'h20};
      do_reset(1);
      repeat (20) tick();
      chk("pre_halt", 32'(halted), 32'h0);
      chk("pre_halt_addr", 32'(rom_addr), 32'h22);
      for (int n = 0; n < 10; n++) begin
         tick();
         chk($sformatf("halt%0d", n), 32'(halted), 32'h1);
         chk($sformatf("halt_op%0d", n), 32'(i_op), 32'(OP_NOPF));
         chk($sformatf("halt_io%0d", n), 32'(io_addr), 32'h1);
         chk($sformatf("halt_addr%0d", n), 32'(rom_addr), 32'h22);
      end
      resume = 1'b1;
      tick();
      resume = 1'b0;
      chk("resume_halt", 32'(halted), 32'h0);
      chk("resume_op", 32'(i_op), 32'(fop(8'h21)));
      chk("resume_addr", 32'(rom_addr), 32'h22);
      tick();
      chk("resume1_op", 32'(i_op), 32'(fop(8'h22)));
      chk("resume1_addr", 32'(rom_addr), 32'h23);

      // Reset while halted with one stack entry live, then RTN on the emptied stack
      do_reset(1);
      repeat (21) tick();
      chk("halt_again", 32'(halted), 32'h1);
      rst_n  = 1'b0;
      resume = 1'b1;
      rom[8'h10] = {OP_RTN, 8'h10};
      tick();
      rst_n  = 1'b1;
      resume = 1'b0;
      chk("midrst_halt", 32'(halted), 32'h0);
      chk("midrst_err", 32'(stk_err), 32'h0);
      chk("midrst_addr", 32'(rom_addr), 32'h0);
      chk("midrst_op", 32'(i_op), 32'h0);
`ifdef SEQ_STACK_EN
      exp_ret = 8'h00;
      exp_err = 1'b1;
`else
      exp_ret = 8'h12;
      exp_err = 1'b0;
`endif
      repeat (17) tick();
      chk("uflow_rtn_op", 32'(i_op), 32'(OP_RTN));
      chk("uflow_pre_err", 32'(stk_err), 32'h0);
      tick();
      chk("uflow_addr", 32'(rom_addr), 32'(exp_ret));
      chk("uflow_err", 32'(stk_err), 32'(exp_err));

      // Random programs against the architectural model
      for (int p = 0; p < 4; p++) begin
         for (int a = 0; a < 256; a++) begin
            r = int'($urandom_range(0, 99));
            if (r < 12) op = OP_JMP;
            else if (r < 22) op = OP_RTN;
            else if (r < 26) op = 4'hE;
            else op = 4'($urandom_range(0, 11));
            rom[a] = {op, 8'($urandom_range(0, 255))};
         end
         do_reset(1);
         model_reset();
         for (int c = 0; c < 150; c++) begin
            tick();
            model_edge();
            model_check(p * 1000 + c);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mc14500_sequencer.md
# mc14500_sequencer

Program sequencer for the MC14500 industrial control unit (ICU): owns the program counter, fetches words from an asynchronous-read program ROM, and presents the opcode nibble on `I` and the I/O select field on `IO_ADDR`. It sits directly upstream of the ICU and consumes the ICU's `JMP`, `RTN` and `FLAG_F` outputs to redirect or stop fetch. It supports one branch delay slot, an optional hardware return stack, and halt/resume on NOPF.

## Interface
- `ADDR_W`, default 8: program counter and ROM address width.
- `STACK_DEPTH`, default 4: return-stack entries; must be a power of two, at least 2.
- `X2` in 1: clock; shared with the ICU. Sequencer state changes on the rising edge only.
- `RST_N` in 1: reset, synchronous, active-low; sampled on the rising edge of `X2`. The ICU must be held in reset over the same cycles.
- `ROM_ADDR` out `ADDR_W`: address of the word being fetched; equals the PC register.
- `ROM_DATA` in `4+ADDR_W`: program word at `ROM_ADDR`, combinational ROM read.
  - Bits `[ADDR_W+3:ADDR_W]` are the opcode.
  - Bits `[ADDR_W-1:0]` are the operand.
- `I` out 4: opcode to the ICU; the ICU samples it on the falling edge of `X2`.
- `IO_ADDR` out 4: `IR[3:0]`, the operand low nibble, used as the I/O or scratch select.
- `JMP` in 1: from the ICU.
- `RTN` in 1: from the ICU.
- `FLAG_F` in 1: from the ICU.
- `RESUME` in 1: leave the halted state; level-sampled.
- `HALTED` out 1: the sequencer is stopped.
- `STK_ERR` out 1: sticky return-stack overflow or underflow.

## Operation
**Registers**
- `PC` (`ADDR_W` bits).
- `IR` (`4+ADDR_W` bits).
- `halted`.
- Stack `stk[STACK_DEPTH]`, stack pointer `sp`, occupancy count `cnt`.
- `stk_err`.

**Reset** (`RST_N`=0 at a rising edge):
- `PC`=0, `IR`=0 (opcode NOPO), `halted`=0.
- `sp`=0, `cnt`=0, `stk_err`=0.
- Outputs after reset: `ROM_ADDR`=0, `I`=0, `IO_ADDR`=0, `HALTED`=0, `STK_ERR`=0.
- Reset overrides every other input.

**Run state** (`halted`=0), at each rising edge, in priority order:
- `JMP`=1:
  - `PC` <= `IR[ADDR_W-1:0]`. `IR` still holds the JMP word at this edge, so this is the JMP word's operand.
  - `IR` <= `ROM_DATA`.
  - With stack enabled: push `PC+1`.
- `RTN`=1:
  - `IR` <= `ROM_DATA`.
  - With stack enabled and `cnt`>0: pop, `PC` <= top.
  - With stack enabled and `cnt`=0: `PC` <= 0, `stk_err` <= 1.
- `FLAG_F`=1:
  - `halted` <= 1.
  - `PC` and `IR` are not updated.
- Otherwise: `IR` <= `ROM_DATA`, `PC` <= `PC+1`.

**Arithmetic**
- `PC+1` wraps modulo 2^`ADDR_W`; the word at the top address is followed by the word at 0.

**Delay slot**
- The word after a JMP or RTN is always fetched and executed.
- A JMP or RTN in the delay slot takes effect normally on its own execute edge.

**Halt state** (`halted`=1)
- `I` is forced to 4'hF (NOPF); `IO_ADDR` still follows `IR`.
- `PC`, `IR` and the stack are frozen.
- `JMP`, `RTN` and `FLAG_F` are ignored.
- `RESUME`=1 at a rising edge: `halted` <= 0 and nothing else changes. On the next falling edge the ICU latches the held `IR` opcode.

**Skipped instructions**
- The ICU masks skipped opcodes itself, so a skipped JMP/RTN/NOPF never reaches the sequencer. No special handling is needed.

## Timing
- Fetch-to-issue latency is 0.5 cycle: `IR` loads on the rising edge, and the ICU latches `I` on the next falling edge.
- The ICU executes on the following rising edge. `JMP`/`RTN`/`FLAG_F` are valid from that falling edge and are sampled at that rising edge.
- JMP at address a:
  - The JMP word is in `IR` after edge k.
  - a+1 is in `IR` after edge k+1; `PC`=target.
  - The target word is in `IR` after edge k+2.
- A taken redirect costs no bubble; the slot is architectural.
- Halt entry:
  - `HALTED`=1 one edge after the NOPF execute edge.
  - The word after NOPF stays in `IR` and is issued after `RESUME`.
- `RESUME` asserted during reset has no effect.
- Reset released mid-halt restarts at address 0.

## Configuration
- `SEQ_STACK_EN` defined:
  - Return stack of `STACK_DEPTH` entries is present.
  - Push when `cnt`=`STACK_DEPTH` is a circular overwrite of the oldest entry: `cnt` stays at `STACK_DEPTH` and `stk_err` <= 1.
  - Pop when `cnt`=0 is an underflow: `PC` <= 0 and `stk_err` <= 1.
  - `stk_err` clears only on reset.
- `SEQ_STACK_EN` undefined:
  - No stack storage.
  - JMP does not push.
  - RTN is treated like a normal fetch (`PC` <= `PC+1`).
  - `STK_ERR` is tied to 0.

## Test plan
- Reset: hold `RST_N`=0 for 3 edges, then release. Required: `ROM_ADDR` 0 → 1 → 2; `I` shows ROM[0] opcode after the first edge; `HALTED`=0; `STK_ERR`=0.
- Linear wrap (`ADDR_W`=4): run 17 edges. Required: `ROM_ADDR` sequence 0..15, 0.
- JMP: JMP with operand 0x40 at 0x10. Required: 0x11 issues as the delay slot, then 0x40, 0x41; the word at 0x12 never issues.
- Call/return with `SEQ_STACK_EN` and a JMP at 0x10:
  - After the JMP, RTN at 0x40. Required: 0x41 issues as the delay slot, then execution resumes at 0x12.
  - Five nested JMPs without RTN (`STACK_DEPTH`=4). Required: `STK_ERR`=1.
  - RTN with empty stack. Required: `PC`=0 and `STK_ERR`=1.
- Halt: NOPF at 0x20. Required: `HALTED`=1, `I`=0xF and `ROM_ADDR` frozen at 0x22 for 10 edges; `RESUME` pulse → the 0x21 opcode issues, then 0x22.
- Reset mid-halt and mid-stack: assert `RST_N`=0 for 1 edge. Required: `HALTED`=0, `cnt`=0, `STK_ERR`=0, `ROM_ADDR`=0.
